// File: rtl/cabac_bin_sched.sv
// ---------------------------------------------------------------------------
// cabac_bin_sched
//
// Purpose:
//   Sequencer and arbiter placed in front of the context-coded bin decoder.
//   It owns the arithmetic-decoder state (ivlCurrRange / ivlOffset) and the
//   RBSP bit window that feeds renormalisation. After the bin decoder reports
//   that context init is complete, it loads the initial 9-bit offset from the
//   window. It then grants single-bin decode requests from two syntax parsers
//   in round-robin order.
//
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   i_slice_start      1-cycle pulse that restarts contexts and arithmetic state
//   i_byte/_valid      RBSP byte input, MSB first
//   o_byte_ready       the window can take a full byte (fill <= BUF_W-8)
//   i_req              per-requester decode request, held until granted
//   i_req_cm_idx       {req1 idx, req0 idx} context indices
//   o_grant            one-hot; the request is consumed this cycle
//   o_bin_valid        one-hot, one cycle after the grant; o_bin is valid
//   o_bin              decoded bin value
//   o_dec_rst          reset to the bin decoder (restarts context init)
//   i_init_done        bin decoder context init complete
//   o_dec_en/o_valid   decode strobe to the bin decoder (identical)
//   o_cm_idx           context index to the bin decoder
//   o_rbsp_win         top 8 bits of the window
//   o_ivlCurrRange     current range to the bin decoder
//   o_ivlOffset        current offset to the bin decoder
//   i_binVal           bin result from the decoder (same cycle as the strobe)
//   i_output_len       bits consumed by renormalisation
//   i_ivlCurrRange     updated range from the bin decoder
//   i_ivlOffset        updated offset from the bin decoder
// ---------------------------------------------------------------------------
module cabac_bin_sched #(
    parameter int NREQ  = 2,
    parameter int BUF_W = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_slice_start,
    input  logic [7:0]        i_byte,
    input  logic              i_byte_valid,
    output logic              o_byte_ready,
    input  logic [NREQ-1:0]   i_req,
    input  logic [NREQ*3-1:0] i_req_cm_idx,
    output logic [NREQ-1:0]   o_grant,
    output logic [NREQ-1:0]   o_bin_valid,
    output logic              o_bin,
    output logic              o_dec_rst,
    input  logic              i_init_done,
    output logic              o_dec_en,
    output logic              o_valid,
    output logic [2:0]        o_cm_idx,
    output logic [7:0]        o_rbsp_win,
    output logic [8:0]        o_ivlCurrRange,
    output logic [8:0]        o_ivlOffset,
    input  logic              i_binVal,
    input  logic [2:0]        i_output_len,
    input  logic [8:0]        i_ivlCurrRange,
    input  logic [8:0]        i_ivlOffset
);

    localparam int FW = $clog2(BUF_W + 1);

    typedef enum logic [1:0] {
        RST_DEC   = 2'd0,
        WAIT_INIT = 2'd1,
        LOAD      = 2'd2,
        READY     = 2'd3
    } state_t;

    state_t            state_reg, state_next;
    logic [BUF_W-1:0]  window_reg, window_next;
    logic [FW-1:0]     fill_reg, fill_next;
    logic [8:0]        range_reg;
    logic [8:0]        offset_reg;
    logic              bin_reg;
    logic [NREQ-1:0]   bin_valid_reg;
    logic              last_reg;

    logic              issue;
    logic              load_fire;
    logic              winner;
    logic              byte_acc;
    logic [FW-1:0]     consume;
    logic [FW-1:0]     fill_shift;
    logic [BUF_W-1:0]  window_shift;
    logic [NREQ-1:0]   grant;
    logic [2:0]        req_idx [NREQ];

    // Per-requester context index slices and one-hot grant decode.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
        assign req_idx[gi] = i_req_cm_idx[gi*3 +: 3];
        assign grant[gi]   = issue && (winner == 1'(gi));
    end

    // Round-robin: when both requesters ask, the one not served last wins.
    always_comb begin
        winner = 1'b0;
        if (i_req[0] && i_req[1]) begin
            winner = ~last_reg;
        end else if (i_req[1]) begin
            winner = 1'b1;
        end
    end

    // Next-state logic. A slice start overrides everything, including any
    // grant that would otherwise happen in the same cycle.
    always_comb begin
        state_next = state_reg;
        issue      = 1'b0;
        load_fire  = 1'b0;
        case (state_reg)
            RST_DEC: begin
                state_next = WAIT_INIT;
            end
            WAIT_INIT: begin
                if (i_init_done) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (fill_reg >= FW'(9)) begin
                    load_fire  = 1'b1;
                    state_next = READY;
                end
            end
            READY: begin
                // Only decode with a full 8-bit window available.
                if ((|i_req) && (fill_reg >= FW'(8))) begin
                    issue = 1'b1;
                end
            end
            default: begin
                state_next = RST_DEC;
            end
        endcase
        if (i_slice_start) begin
            state_next = RST_DEC;
            issue      = 1'b0;
            load_fire  = 1'b0;
        end
    end

    // Window: shift out consumed bits first, then append the new byte right
    // behind the remaining valid bits.
    assign o_byte_ready = (fill_reg <= FW'(BUF_W - 8));
    assign byte_acc     = i_byte_valid && o_byte_ready;

    always_comb begin
        consume = '0;
        if (issue) begin
            consume = FW'(i_output_len);
        end else if (load_fire) begin
            consume = FW'(9);
        end
        fill_shift   = fill_reg - consume;
        window_shift = window_reg << consume;
        window_next  = window_shift;
        fill_next    = fill_shift;
        if (byte_acc) begin
            window_next = window_shift | ({i_byte, {(BUF_W-8){1'b0}}} >> fill_shift);
            fill_next   = fill_shift + FW'(8);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= RST_DEC;
            window_reg    <= '0;
            fill_reg      <= '0;
            range_reg     <= 9'd510;
            offset_reg    <= '0;
            bin_reg       <= 1'b0;
            bin_valid_reg <= '0;
            last_reg      <= 1'b1;
        end else begin
            state_reg     <= state_next;
            window_reg    <= window_next;
            fill_reg      <= fill_next;
            bin_valid_reg <= grant;
            if (i_slice_start) begin
                range_reg  <= 9'd510;
                offset_reg <= '0;
            end else if (load_fire) begin
                range_reg  <= 9'd510;
                offset_reg <= window_reg[BUF_W-1 -: 9];
            end else if (issue) begin
                range_reg  <= i_ivlCurrRange;
                offset_reg <= i_ivlOffset;
                bin_reg    <= i_binVal;
                last_reg   <= winner;
            end
        end
    end

    assign o_grant        = grant;
    assign o_bin_valid    = bin_valid_reg;
    assign o_bin          = bin_reg;
    assign o_dec_rst      = (state_reg == RST_DEC);
    assign o_dec_en       = issue;
    assign o_valid        = issue;
    assign o_cm_idx       = issue ? req_idx[winner] : 3'd0;
    assign o_rbsp_win     = window_reg[BUF_W-1 -: 8];
    assign o_ivlCurrRange = range_reg;
    assign o_ivlOffset    = offset_reg;

endmodule

// File: tb/tb_cabac_bin_sched.sv
// ---------------------------------------------------------------------------
// tb_cabac_bin_sched
//
// Directed bench for cabac_bin_sched. Inputs change 1 time unit after the
// rising edge; outputs are checked 1 more unit later, well away from the edge.
// Expected window contents and states are worked out by hand for each step.
// ---------------------------------------------------------------------------
module tb_cabac_bin_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_slice_start;
    logic [7:0] i_byte;
    logic       i_byte_valid;
    logic       o_byte_ready;
    logic [1:0] i_req;
    logic [5:0] i_req_cm_idx;
    logic [1:0] o_grant;
    logic [1:0] o_bin_valid;
    logic       o_bin;
    logic       o_dec_rst;
    logic       i_init_done;
    logic       o_dec_en;
    logic       o_valid;
    logic [2:0] o_cm_idx;
    logic [7:0] o_rbsp_win;
    logic [8:0] o_ivlCurrRange;
    logic [8:0] o_ivlOffset;
    logic       i_binVal;
    logic [2:0] i_output_len;
    logic [8:0] i_ivlCurrRange;
    logic [8:0] i_ivlOffset;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cabac_bin_sched #(.NREQ(2), .BUF_W(24)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_slice_start  (i_slice_start),
        .i_byte         (i_byte),
        .i_byte_valid   (i_byte_valid),
        .o_byte_ready   (o_byte_ready),
        .i_req          (i_req),
        .i_req_cm_idx   (i_req_cm_idx),
        .o_grant        (o_grant),
        .o_bin_valid    (o_bin_valid),
        .o_bin          (o_bin),
        .o_dec_rst      (o_dec_rst),
        .i_init_done    (i_init_done),
        .o_dec_en       (o_dec_en),
        .o_valid        (o_valid),
        .o_cm_idx       (o_cm_idx),
        .o_rbsp_win     (o_rbsp_win),
        .o_ivlCurrRange (o_ivlCurrRange),
        .o_ivlOffset    (o_ivlOffset),
        .i_binVal       (i_binVal),
        .i_output_len   (i_output_len),
        .i_ivlCurrRange (i_ivlCurrRange),
        .i_ivlOffset    (i_ivlOffset)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Give combinational outputs time to settle after driving inputs.
    task automatic settle();
        #1;
    endtask

    initial begin
        rst            = 1'b1;
        i_slice_start  = 1'b0;
        i_byte         = 8'h00;
        i_byte_valid   = 1'b0;
        i_req          = 2'b00;
        i_req_cm_idx   = {3'd5, 3'd2};
        i_init_done    = 1'b0;
        i_binVal       = 1'b0;
        i_output_len   = 3'd0;
        i_ivlCurrRange = 9'd0;
        i_ivlOffset    = 9'd0;

        // 1: reset values
        step(); step(); settle();
        chk("rst_dec_rst",   32'(o_dec_rst), 32'd1);
        chk("rst_range",     32'(o_ivlCurrRange), 32'd510);
        chk("rst_offset",    32'(o_ivlOffset), 32'd0);
        chk("rst_grant",     32'(o_grant), 32'd0);
        chk("rst_bin_valid", 32'(o_bin_valid), 32'd0);
        chk("rst_dec_en",    32'(o_dec_en), 32'd0);
        chk("rst_ready",     32'(o_byte_ready), 32'd1);
        $display("step rst: dec_rst=%0d range=%0d ready=%0d", o_dec_rst, o_ivlCurrRange, o_byte_ready);

        rst = 1'b0;
        settle();
        chk("rst_release_dec_rst", 32'(o_dec_rst), 32'd1);
        step(); settle();
        chk("wait_init_dec_rst", 32'(o_dec_rst), 32'd0);

        // 2: init done, bytes A5 and 3C, initial offset load
        i_init_done  = 1'b1;
        i_byte_valid = 1'b1;
        i_byte       = 8'hA5;
        step();
        i_byte = 8'h3C;
        step();
        i_byte_valid = 1'b0;
        step(); settle();
        chk("load_offset", 32'(o_ivlOffset), 32'h14A);
        chk("load_range",  32'(o_ivlCurrRange), 32'd510);
        chk("load_win",    32'(o_rbsp_win), 32'h78);
        $display("step load: offset=0x%0h win=0x%0h", o_ivlOffset, o_rbsp_win);

        // fill is 7: request must wait
        i_req = 2'b01;
        settle();
        chk("partial_grant",  32'(o_grant), 32'd0);
        chk("partial_dec_en", 32'(o_dec_en), 32'd0);
        step(); settle();
        chk("partial_grant2",     32'(o_grant), 32'd0);
        chk("partial_bin_valid",  32'(o_bin_valid), 32'd0);
        i_byte_valid = 1'b1;
        i_byte       = 8'hB2;
        settle();
        chk("partial_grant3", 32'(o_grant), 32'd0);
        step();

        // 4: first grant, len 6 with a simultaneous byte push (fill 15 -> 17)
        i_byte         = 8'hFF;
        i_output_len   = 3'd6;
        i_ivlCurrRange = 9'd300;
        i_ivlOffset    = 9'd100;
        i_binVal       = 1'b1;
        settle();
        chk("g0_grant",  32'(o_grant), 32'b01);
        chk("g0_dec_en", 32'(o_dec_en), 32'd1);
        chk("g0_valid",  32'(o_valid), 32'd1);
        chk("g0_cm_idx", 32'(o_cm_idx), 32'd2);
        chk("g0_win",    32'(o_rbsp_win), 32'h79);
        chk("g0_offset", 32'(o_ivlOffset), 32'h14A);
        $display("step g0: grant=%b cm_idx=%0d win=0x%0h", o_grant, o_cm_idx, o_rbsp_win);
        step();

        // 3: both requesters, len 1 each, alternating grants
        i_byte_valid   = 1'b0;
        i_req          = 2'b11;
        i_output_len   = 3'd1;
        i_ivlCurrRange = 9'd400;
        i_ivlOffset    = 9'd10;
        i_binVal       = 1'b0;
        settle();
        chk("g0_bin_valid", 32'(o_bin_valid), 32'b01);
        chk("g0_bin",       32'(o_bin), 32'd1);
        chk("g0_range_upd", 32'(o_ivlCurrRange), 32'd300);
        chk("g0_off_upd",   32'(o_ivlOffset), 32'd100);
        chk("g0_win_after", 32'(o_rbsp_win), 32'h59);
        chk("fill17_ready", 32'(o_byte_ready), 32'd0);
        chk("a_grant",      32'(o_grant), 32'b10);
        chk("a_cm_idx",     32'(o_cm_idx), 32'd5);
        $display("step A: grant=%b cm_idx=%0d", o_grant, o_cm_idx);
        step();

        i_ivlCurrRange = 9'd401;
        i_ivlOffset    = 9'd11;
        i_binVal       = 1'b1;
        settle();
        chk("b_grant",     32'(o_grant), 32'b01);
        chk("b_cm_idx",    32'(o_cm_idx), 32'd2);
        chk("b_bin_valid", 32'(o_bin_valid), 32'b10);
        chk("b_bin",       32'(o_bin), 32'd0);
        chk("b_range",     32'(o_ivlCurrRange), 32'd400);
        chk("b_win",       32'(o_rbsp_win), 32'hB2);
        chk("b_ready",     32'(o_byte_ready), 32'd1);
        $display("step B: grant=%b cm_idx=%0d", o_grant, o_cm_idx);
        step();

        i_ivlCurrRange = 9'd402;
        i_ivlOffset    = 9'd12;
        i_binVal       = 1'b0;
        settle();
        chk("c_grant",     32'(o_grant), 32'b10);
        chk("c_bin_valid", 32'(o_bin_valid), 32'b01);
        chk("c_bin",       32'(o_bin), 32'd1);
        chk("c_range",     32'(o_ivlCurrRange), 32'd401);
        chk("c_win",       32'(o_rbsp_win), 32'h65);
        $display("step C: grant=%b", o_grant);
        step();

        // 6: fill the window up to 24
        i_req        = 2'b00;
        i_byte_valid = 1'b1;
        i_byte       = 8'h11;
        settle();
        chk("d_grant",     32'(o_grant), 32'd0);
        chk("d_bin_valid", 32'(o_bin_valid), 32'b10);
        chk("d_bin",       32'(o_bin), 32'd0);
        chk("d_range",     32'(o_ivlCurrRange), 32'd402);
        chk("d_offset",    32'(o_ivlOffset), 32'd12);
        chk("d_win",       32'(o_rbsp_win), 32'hCB);
        chk("d_ready",     32'(o_byte_ready), 32'd1);
        step();

        i_req        = 2'b01;
        i_output_len = 3'd6;
        i_byte       = 8'h22;
        settle();
        chk("e_ready", 32'(o_byte_ready), 32'd0);
        chk("e_grant", 32'(o_grant), 32'b01);
        step();

        i_req  = 2'b00;
        i_byte = 8'h33;
        settle();
        chk("f_ready", 32'(o_byte_ready), 32'd1);
        chk("f_win",   32'(o_rbsp_win), 32'hFF);
        step();

        i_byte = 8'h44;
        i_req  = 2'b10;
        settle();
        chk("full_ready", 32'(o_byte_ready), 32'd0);
        chk("g_grant",    32'(o_grant), 32'b10);
        $display("step full: ready=%0d win=0x%0h", o_byte_ready, o_rbsp_win);
        step();

        i_byte_valid = 1'b0;
        i_req        = 2'b01;
        settle();
        chk("h_win",   32'(o_rbsp_win), 32'hC4);
        chk("h_ready", 32'(o_byte_ready), 32'd0);
        chk("h_grant", 32'(o_grant), 32'b01);
        step();

        // 5: slice start in a cycle that would otherwise grant
        i_slice_start = 1'b1;
        settle();
        chk("i_win",    32'(o_rbsp_win), 32'h13);
        chk("i_ready",  32'(o_byte_ready), 32'd1);
        chk("i_grant",  32'(o_grant), 32'd0);
        chk("i_dec_en", 32'(o_dec_en), 32'd0);
        step();

        i_slice_start = 1'b0;
        i_init_done   = 1'b0;
        settle();
        chk("j_bin_valid", 32'(o_bin_valid), 32'd0);
        chk("j_dec_rst",   32'(o_dec_rst), 32'd1);
        chk("j_range",     32'(o_ivlCurrRange), 32'd510);
        chk("j_offset",    32'(o_ivlOffset), 32'd0);
        chk("j_grant",     32'(o_grant), 32'd0);
        $display("step slice: dec_rst=%0d range=%0d bin_valid=%b", o_dec_rst, o_ivlCurrRange, o_bin_valid);
        step();

        chk("k_dec_rst",   32'(o_dec_rst), 32'd0);
        chk("k_grant",     32'(o_grant), 32'd0);
        chk("k_bin_valid", 32'(o_bin_valid), 32'd0);
        i_init_done = 1'b1;
        step(); settle();
        chk("l_grant", 32'(o_grant), 32'd0);
        step(); settle();
        chk("m_offset", 32'(o_ivlOffset), 32'h026);
        chk("m_range",  32'(o_ivlCurrRange), 32'd510);
        chk("m_win",    32'(o_rbsp_win), 32'h60);
        chk("m_grant",  32'(o_grant), 32'd0);
        $display("step reload: offset=0x%0h win=0x%0h", o_ivlOffset, o_rbsp_win);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
